// File: rtl/dpd_digit_stream_if.sv
// dpd_digit_stream_if
//   Groups the two streams of the densely-packed-decimal digit serializer.
//   Word side : in_valid / in_ready / in_data / in_last
//               (a word is DECLETS packed declets, most significant declet on top).
//   Digit side: out_valid / out_ready / out_digit / out_last /
//               out_noncanon / out_index.
//   Modports:
//     master - the environment: drives words, consumes digits.
//     slave  - the serializer itself.
interface dpd_digit_stream_if #(
  parameter int DECLETS = 2,
  parameter int IDX_W   = 16
);
  logic                   in_valid;
  logic                   in_ready;
  logic [10*DECLETS-1:0]  in_data;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [3:0]             out_digit;
  logic                   out_last;
  logic                   out_noncanon;
  logic [IDX_W-1:0]       out_index;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_digit, out_last, out_noncanon, out_index
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_digit, out_last, out_noncanon, out_index
  );
endinterface

// File: rtl/dpd_digit_stream.sv
// dpd_digit_stream
//   Accepts words of DECLETS densely-packed-decimal declets and emits them
//   as a stream of BCD digits, most significant declet first, d2/d1/d0
//   within each declet. One word is buffered; the next word is accepted
//   in the same cycle the buffered word's final digit leaves, so back-to-back
//   words stream without a bubble.
//   Ports:
//     clk    - single rising-edge clock
//     rst_n  - synchronous active-low reset
//     stream - dpd_digit_stream_if.slave (word input / digit output handshakes)
//   All digit-side outputs are registered; in_ready is combinational from
//   the buffer state and out_ready.
module dpd_digit_stream #(
  parameter int DECLETS = 2,
  parameter int IDX_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  dpd_digit_stream_if.slave stream
);

  localparam int DW    = 10 * DECLETS;
  localparam int SEL_W = (DECLETS > 1) ? $clog2(DECLETS) : 1;
  localparam logic [SEL_W-1:0] LAST_DECL = SEL_W'(DECLETS - 1);

  // Decode one declet into {noncanon, d2, d1, d0}. The 0xx case is the
  // default: every digit is a small digit taken straight from its field.
  function automatic logic [12:0] decode_declet(input logic [9:0] b);
    logic [3:0] d2;
    logic [3:0] d1;
    logic [3:0] d0;
    logic       nc;
    d2 = {1'b0, b[9:7]};
    d1 = {1'b0, b[6:4]};
    d0 = {1'b0, b[2:0]};
    nc = 1'b0;
    if (b[3]) begin
      case (b[2:1])
        2'b00: d0 = {3'b100, b[0]};
        2'b01: begin
          d1 = {3'b100, b[4]};
          d0 = {1'b0, b[6:5], b[0]};
        end
        2'b10: begin
          d2 = {3'b100, b[7]};
          d0 = {1'b0, b[9:8], b[0]};
        end
        default: begin
          case (b[6:5])
            2'b00: begin
              d2 = {3'b100, b[7]};
              d1 = {3'b100, b[4]};
              d0 = {1'b0, b[9:8], b[0]};
            end
            2'b01: begin
              d2 = {3'b100, b[7]};
              d1 = {1'b0, b[9:8], b[4]};
              d0 = {3'b100, b[0]};
            end
            2'b10: begin
              d1 = {3'b100, b[4]};
              d0 = {3'b100, b[0]};
            end
            default: begin
              d2 = {3'b100, b[7]};
              d1 = {3'b100, b[4]};
              d0 = {3'b100, b[0]};
              // All three digits are large, so b9b8 carry no information;
              // any non-zero value there is a redundant encoding.
              nc = |b[9:8];
            end
          endcase
        end
      endcase
    end
    return {nc, d2, d1, d0};
  endfunction

  typedef enum logic {ST_EMPTY = 1'b0, ST_BUSY = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    data_q, data_d;
  logic             last_q, last_d;
  // decl_q counts declets already consumed (0 = most significant declet),
  // pos_q selects d2/d1/d0 inside it; together they form the digit counter.
  logic [SEL_W-1:0] decl_q, decl_d;
  logic [1:0]       pos_q, pos_d;

  logic             out_valid_q, out_valid_d;
  logic [3:0]       out_digit_q, out_digit_d;
  logic             out_last_q, out_last_d;
  logic             out_nc_q, out_nc_d;
  logic [IDX_W-1:0] out_index_q, out_index_d;

  logic             out_fire;
  logic             final_digit;
  logic             final_fire;
  logic             in_ready;
  logic             in_fire;
  logic [12:0]      dec_w [DECLETS];
  logic [12:0]      dec_sel;

  // Handshake qualifiers.
  always_comb begin
    out_fire    = (state_q == ST_BUSY) && stream.out_ready;
    final_digit = (decl_q == LAST_DECL) && (pos_q == 2'd2);
    final_fire  = out_fire && final_digit;
    in_fire     = stream.in_valid && in_ready;
  end

  // FSM: state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (stream.in_valid) state_d = ST_BUSY;
      ST_BUSY:  if (final_fire && !stream.in_valid) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // FSM: outputs. Accepting while the final digit leaves keeps streams gap-free.
  always_comb begin
    in_ready = (state_q == ST_EMPTY) || final_fire;
  end

  assign stream.in_ready = in_ready;

  // Buffer and digit counter next state.
  always_comb begin
    data_d = data_q;
    last_d = last_q;
    decl_d = decl_q;
    pos_d  = pos_q;
    if (in_fire) begin
      data_d = stream.in_data;
      last_d = stream.in_last;
      decl_d = '0;
      pos_d  = 2'd0;
    end else if (final_fire) begin
      decl_d = '0;
      pos_d  = 2'd0;
    end else if (out_fire) begin
      if (pos_q == 2'd2) begin
        pos_d  = 2'd0;
        decl_d = decl_q + 1'b1;
      end else begin
        pos_d  = pos_q + 2'd1;
      end
    end
  end

  // Decode every declet of the next buffer contents; element 0 holds the
  // most significant declet so the counter walks the array upward.
  generate
    for (genvar gi = 0; gi < DECLETS; gi++) begin : g_dec
      assign dec_w[gi] = decode_declet(data_d[10*(DECLETS-1-gi) +: 10]);
    end
  endgenerate

  // Output registers are loaded from the next-state buffer/counter so the
  // presented digit always matches what the counter points at, and holds
  // naturally while stalled.
  always_comb begin
    dec_sel = dec_w[0];
    for (int k = 0; k < DECLETS; k++) begin
      if (decl_d == SEL_W'(k)) dec_sel = dec_w[k];
    end

    out_valid_d = (state_d == ST_BUSY);
    out_nc_d    = dec_sel[12];
    case (pos_d)
      2'd0:    out_digit_d = dec_sel[11:8];
      2'd1:    out_digit_d = dec_sel[7:4];
      default: out_digit_d = dec_sel[3:0];
    endcase
    out_last_d = (state_d == ST_BUSY) && last_d &&
                 (decl_d == LAST_DECL) && (pos_d == 2'd2);

    // Index tracks the presented digit: it restarts after a frame end and
    // otherwise counts up, sticking at all-ones for over-long frames.
    out_index_d = out_index_q;
    if (out_fire) begin
      if (out_last_q)        out_index_d = '0;
      else if (&out_index_q) out_index_d = out_index_q;
      else                   out_index_d = out_index_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q      <= '0;
      last_q      <= 1'b0;
      decl_q      <= '0;
      pos_q       <= 2'd0;
      out_valid_q <= 1'b0;
      out_digit_q <= 4'd0;
      out_last_q  <= 1'b0;
      out_nc_q    <= 1'b0;
      out_index_q <= '0;
    end else begin
      data_q      <= data_d;
      last_q      <= last_d;
      decl_q      <= decl_d;
      pos_q       <= pos_d;
      out_valid_q <= out_valid_d;
      out_digit_q <= out_digit_d;
      out_last_q  <= out_last_d;
      out_nc_q    <= out_nc_d;
      out_index_q <= out_index_d;
    end
  end

  assign stream.out_valid    = out_valid_q;
  assign stream.out_digit    = out_digit_q;
  assign stream.out_last     = out_last_q;
  assign stream.out_noncanon = out_nc_q;
  assign stream.out_index    = out_index_q;

endmodule

// File: tb/tb_dpd_digit_stream.sv
// tb_dpd_digit_stream
//   Two serializers: A (2 declets/word, 3-bit index) for the directed,
//   backpressure, frame-index and reset scenarios; B (1 declet/word,
//   16-bit index) for a sweep over all 1024 declets. Expected digits come
//   from a table-driven reference decoder and a frame-position model.
module tb_dpd_digit_stream;

  localparam int DA = 2;
  localparam int WA = 3;
  localparam int DB = 1;
  localparam int WB = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dpd_digit_stream_if #(.DECLETS(DA), .IDX_W(WA)) bus_a ();
  dpd_digit_stream_if #(.DECLETS(DB), .IDX_W(WB)) bus_b ();

  dpd_digit_stream #(.DECLETS(DA), .IDX_W(WA)) dut_a (.clk(clk), .rst_n(rst_n), .stream(bus_a));
  dpd_digit_stream #(.DECLETS(DB), .IDX_W(WB)) dut_b (.clk(clk), .rst_n(rst_n), .stream(bus_b));

  typedef struct {
    int digit;
    int nc;
    int last;
    int idx;
    int wend;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   fpos [2];
  int   ndig [2];
  bit   stall[2];
  int   h_dig[2], h_nc[2], h_last[2], h_idx[2];
  bit   rand_mode;
  int   n_checks;
  int   n_errors;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference decoder written from the declet table: a "small" digit is
  // 2*field + lsb (0..7), a "large" digit is 8 + lsb (8 or 9).
  task automatic ref_decode(input logic [9:0] b, output int hi, output int mid, output int lo,
                            output int nc);
    int p, q, r, l2, l1, l0;
    p = int'(b[9:8]); q = int'(b[6:5]); r = int'(b[2:1]);
    l2 = int'(b[7]);  l1 = int'(b[4]);  l0 = int'(b[0]);
    nc = 0;
    if (b[3] == 1'b0) begin
      hi = 2*p + l2; mid = 2*q + l1; lo = 2*r + l0;
    end else if (r == 0) begin
      hi = 2*p + l2; mid = 2*q + l1; lo = 8 + l0;
    end else if (r == 1) begin
      hi = 2*p + l2; mid = 8 + l1;   lo = 2*q + l0;
    end else if (r == 2) begin
      hi = 8 + l2;   mid = 2*q + l1; lo = 2*p + l0;
    end else if (q == 0) begin
      hi = 8 + l2;   mid = 8 + l1;   lo = 2*p + l0;
    end else if (q == 1) begin
      hi = 8 + l2;   mid = 2*p + l1; lo = 8 + l0;
    end else if (q == 2) begin
      hi = 2*p + l2; mid = 8 + l1;   lo = 8 + l0;
    end else begin
      hi = 8 + l2;   mid = 8 + l1;   lo = 8 + l0;
      nc = (p != 0) ? 1 : 0;
    end
  endtask

  function automatic int qsize(input int w);
    return (w == 0) ? q_a.size() : q_b.size();
  endfunction

  // Append the digits of one accepted word to the expected stream.
  task automatic model_word(input int w, input logic [19:0] data, input logic last);
    int nd, maxi, hi, mid, lo, nc;
    int dg[3];
    logic [9:0] dl;
    exp_t e;
    nd   = (w == 0) ? DA : DB;
    maxi = (w == 0) ? ((1 << WA) - 1) : ((1 << WB) - 1);
    for (int k = nd - 1; k >= 0; k--) begin
      dl = data[10*k +: 10];
      ref_decode(dl, hi, mid, lo, nc);
      dg[0] = hi; dg[1] = mid; dg[2] = lo;
      for (int j = 0; j < 3; j++) begin
        e.digit = dg[j];
        e.nc    = nc;
        e.wend  = (k == 0 && j == 2) ? 1 : 0;
        e.last  = (e.wend == 1 && last) ? 1 : 0;
        e.idx   = (fpos[w] > maxi) ? maxi : fpos[w];
        fpos[w] = (e.last == 1) ? 0 : fpos[w] + 1;
        if (w == 0) q_a.push_back(e); else q_b.push_back(e);
      end
    end
  endtask

  // Offer a word (called at posedge+1); returns at posedge+1 after acceptance
  // with in_valid still high so consecutive calls stream back to back.
  task automatic send(input int w, input logic [19:0] data, input logic last);
    int waited;
    bit done;
    waited = 0;
    done   = 0;
    if (w == 0) begin
      bus_a.in_valid = 1'b1; bus_a.in_data = data; bus_a.in_last = last;
    end else begin
      bus_b.in_valid = 1'b1; bus_b.in_data = data[9:0]; bus_b.in_last = last;
    end
    while (!done) begin
      @(negedge clk);
      if (((w == 0) ? bus_a.in_ready : bus_b.in_ready) == 1'b1) begin
        model_word(w, data, last);
        done = 1;
      end else if (waited >= 100) begin
        check_eq((w == 0) ? "A_in_ready_wait" : "B_in_ready_wait",
                 32'((w == 0) ? bus_a.in_ready : bus_b.in_ready), 1);
        done = 1;
      end
      waited++;
      @(posedge clk); #1;
    end
  endtask

  task automatic drain(input int w, input int budget);
    int n;
    n = 0;
    while (qsize(w) != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check_eq((w == 0) ? "A_drain" : "B_drain", qsize(w), 0);
    @(posedge clk); #1;
  endtask

  task automatic mon(input int w, input logic v, input logic rdy, input logic irdy,
                     input logic [3:0] dg, input logic nc, input logic ls, input logic [31:0] ix);
    exp_t  e;
    string nm;
    nm = (w == 0) ? "A" : "B";
    if (stall[w]) begin
      check_eq({nm, "_hold_valid"}, 32'(v), 1);
      check_eq({nm, "_hold_digit"}, 32'(dg), h_dig[w]);
      check_eq({nm, "_hold_nc"}, 32'(nc), h_nc[w]);
      check_eq({nm, "_hold_last"}, 32'(ls), h_last[w]);
      check_eq({nm, "_hold_index"}, ix, h_idx[w]);
    end
    if (v && rdy) begin
      if (qsize(w) == 0) begin
        check_eq({nm, "_spurious_digit"}, 32'(v), 0);
      end else begin
        if (w == 0) e = q_a.pop_front(); else e = q_b.pop_front();
        check_eq({nm, "_digit"}, 32'(dg), e.digit);
        check_eq({nm, "_noncanon"}, 32'(nc), e.nc);
        check_eq({nm, "_last"}, 32'(ls), e.last);
        check_eq({nm, "_index"}, ix, e.idx);
        check_eq({nm, "_in_ready_at_digit"}, 32'(irdy), e.wend);
        $display("%s digit #%0d: digit=%0d nc=%0d last=%0d index=%0d in_ready=%0d",
                 nm, ndig[w], dg, nc, ls, ix, irdy);
        ndig[w]++;
      end
    end
    stall[w] = v && !rdy;
    h_dig[w] = int'(dg); h_nc[w] = int'(nc); h_last[w] = int'(ls); h_idx[w] = int'(ix);
  endtask

  // Digit monitor for both instances.
  initial begin
    stall[0] = 0; stall[1] = 0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        mon(0, bus_a.out_valid, bus_a.out_ready, bus_a.in_ready, bus_a.out_digit,
            bus_a.out_noncanon, bus_a.out_last, 32'(bus_a.out_index));
        mon(1, bus_b.out_valid, bus_b.out_ready, bus_b.in_ready, bus_b.out_digit,
            bus_b.out_noncanon, bus_b.out_last, 32'(bus_b.out_index));
      end else begin
        stall[0] = 0; stall[1] = 0;
      end
    end
  end

  // Sink for A: always ready, or a coin flip each cycle.
  initial begin
    bus_a.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus_a.out_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int waited;
    n_checks = 0; n_errors = 0;
    fpos[0] = 0; fpos[1] = 0; ndig[0] = 0; ndig[1] = 0;
    rand_mode = 0;
    rst_n = 1'b0;
    bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.in_last = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.in_last = 1'b0;
    bus_b.out_ready = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_eq("A_rst_valid", 32'(bus_a.out_valid), 0);
    check_eq("A_rst_digit", 32'(bus_a.out_digit), 0);
    check_eq("A_rst_last", 32'(bus_a.out_last), 0);
    check_eq("A_rst_nc", 32'(bus_a.out_noncanon), 0);
    check_eq("A_rst_index", 32'(bus_a.out_index), 0);
    check_eq("B_rst_valid", 32'(bus_b.out_valid), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("A_in_ready_after_rst", 32'(bus_a.in_ready), 1);
    check_eq("B_in_ready_after_rst", 32'(bus_b.in_ready), 1);

    // 314159 example, then first-digit latency.
    send(0, {10'h194, 10'h0D9}, 1'b1);
    bus_a.in_valid = 1'b0;
    check_eq("A_latency_valid", 32'(bus_a.out_valid), 1);
    check_eq("A_latency_digit", 32'(bus_a.out_digit), 3);
    drain(0, 50);

    // Decode corners, streamed back to back.
    send(0, {10'h00C, 10'h0FF}, 1'b0);
    send(0, {10'h3FF, 10'h165}, 1'b1);
    bus_a.in_valid = 1'b0;
    drain(0, 50);

    // One 4-word frame (index saturates at 7), then a 1-word frame.
    for (int i = 0; i < 4; i++) send(0, 20'($urandom_range(0, 20'hFFFFF)), (i == 3));
    send(0, 20'($urandom_range(0, 20'hFFFFF)), 1'b1);
    bus_a.in_valid = 1'b0;
    drain(0, 100);

    // Random words under random backpressure.
    rand_mode = 1;
    for (int i = 0; i < 30; i++) begin
      send(0, 20'($urandom_range(0, 20'hFFFFF)), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 2) == 0) begin
        bus_a.in_valid = 1'b0;
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end
    end
    bus_a.in_valid = 1'b0;
    drain(0, 2000);
    rand_mode = 0;
    @(posedge clk); #1;

    // Reset after the second digit of a word.
    base = ndig[0];
    send(0, {10'h194, 10'h0D9}, 1'b1);
    bus_a.in_valid = 1'b0;
    waited = 0;
    while (ndig[0] < base + 2 && waited < 50) begin
      @(negedge clk); #1;
      waited++;
    end
    check_eq("A_rst_mid_two_digits", ndig[0] - base, 2);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_eq("A_rst_mid_valid", 32'(bus_a.out_valid), 0);
    check_eq("A_rst_mid_index", 32'(bus_a.out_index), 0);
    rst_n = 1'b1;
    q_a.delete(); fpos[0] = 0; fpos[1] = 0;
    @(posedge clk); #1;
    check_eq("A_no_partial_after_rst", 32'(bus_a.out_valid), 0);
    send(0, {10'h165, 10'h3FF}, 1'b1);
    bus_a.in_valid = 1'b0;
    check_eq("A_post_rst_first_index", 32'(bus_a.out_index), 0);
    check_eq("A_post_rst_first_digit", 32'(bus_a.out_digit), 2);
    drain(0, 50);

    // Every declet through the single-declet instance.
    for (int v = 0; v < 1024; v++) send(1, 20'(v), ($urandom_range(0, 4) == 0));
    bus_b.in_valid = 1'b0;
    drain(1, 100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
